// File: rtl/spmac.sv
// Sign-magnitude coefficient multiply-accumulate: one shift-add per magnitude bit,
// with saturating accumulation into result_out. Define SPMAC_ROUND_EN for round-half-up scaling.
module spmac #(
    parameter int SIG_W  = 16,
    parameter int COEF_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIG_W-1:0]  sig_in,
    input  logic [COEF_W-1:0] coef_in,
    input  logic              start,
    input  logic              acc_in,
    output logic [SIG_W-1:0]  result_out,
    output logic              done,
    output logic              ovf,
    output logic [1:0]        state_dbg
);
    localparam int MAG_W = COEF_W - 1;
    localparam int P_W   = SIG_W + MAG_W;
    localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [SIG_W-1:0] SAT_MAX = {1'b0, {(SIG_W-1){1'b1}}};
    localparam logic [SIG_W-1:0] SAT_MIN = {1'b1, {(SIG_W-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic             accm_q, accm_d;
    logic [P_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIG_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    logic [P_W-1:0]        sig_ext;
    logic signed [P_W:0]   full_w;
    logic signed [P_W:0]   rnd_w;
    logic signed [SIG_W:0] scaled_w;
    logic signed [SIG_W:0] sum_w;
    logic                  sum_ovf;

    assign sig_ext = {{MAG_W{sig_q[SIG_W-1]}}, sig_q};

    // Sign goes on the exact product before scaling, so -0 naturally yields 0.
    always_comb begin
        full_w = $signed({acc_q[P_W-1], acc_q});
        if (neg_q) full_w = -full_w;
`ifdef SPMAC_ROUND_EN
        rnd_w = full_w + $signed((P_W+1)'(1) << (COEF_W-2));
`else
        rnd_w = full_w;
`endif
        scaled_w = (SIG_W+1)'(rnd_w >>> MAG_W);
        sum_w    = scaled_w + (accm_q ? $signed({result_q[SIG_W-1], result_q}) : '0);
        sum_ovf  = sum_w[SIG_W] != sum_w[SIG_W-1];
    end

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        accm_d   = accm_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                sig_d  = sig_in;
                mag_d  = coef_in[MAG_W-1:0];
                neg_d  = coef_in[COEF_W-1];
                accm_d = acc_in;
                acc_d  = '0;
                cnt_d  = CNT_W'(MAG_W - 1);
                if (start) state_d = S_MUL;
            end
            S_MUL: begin
                // MSB-first shift-add over the magnitude bits
                acc_d = (acc_q << 1) + (mag_q[cnt_q] ? sig_ext : '0);
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIN;
            end
            S_FIN: begin
                ovf_d    = sum_ovf;
                result_d = sum_ovf ? (sum_w[SIG_W] ? SAT_MIN : SAT_MAX) : sum_w[SIG_W-1:0];
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sig_q    <= '0;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            accm_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            mag_q    <= mag_d;
            neg_q    <= neg_d;
            accm_q   <= accm_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result_out = result_q;
    assign ovf        = ovf_q;
    assign done       = (state_q == S_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: doc/spmac.md
SPMAC -- requirements
Module: spmac

Interface
REQ-001 The block SHALL have parameter SIG_W, default 16, signal operand and result width in bits (range 8..24).
REQ-002 The block SHALL have parameter COEF_W, default 10, coefficient width including sign bit (range 4..16).
REQ-003 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port sig_in  input  SIG_W  signed two's-complement signal operand.
REQ-006 The block SHALL have port coef_in  input  COEF_W  sign-magnitude coefficient: MSB is sign, lower COEF_W-1 bits are fraction magnitude (value = ±mag/2^(COEF_W-1)).
REQ-007 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-008 The block SHALL have port acc_in  input  1  accumulate mode; sampled with start.
REQ-009 The block SHALL have port result_out  output  SIG_W  signed result, held until the next completion.
REQ-010 The block SHALL have port done  output  1  high when idle/ready; low while busy.
REQ-011 The block SHALL have port ovf  output  1  saturation flag for the current result_out, updated together with result_out.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, FIN; IDLE->MUL on start=1; MUL->FIN after COEF_W-1 cycles; FIN->IDLE unconditionally.
REQ-013 In IDLE, every cycle: latch sig_in, coef_in, acc_in; clear accumulator; done=1.
REQ-014 start sampled high at edge E0 SHALL make done low from E1, and update result_out/ovf with done=1 at edge E(COEF_W) (E10 at defaults); next start is accepted at E(COEF_W+1).
REQ-015 MUL SHALL perform one MSB-first shift-add per cycle over the magnitude bits (acc = 2·acc + (bit ? sig : 0)), giving an exact SIG_W+COEF_W-1-bit product.
REQ-016 In FIN, the sign SHALL be applied to the full product before scaling (negate when coefficient sign=1); a magnitude of zero with sign=1 SHALL yield 0.
REQ-017 Scaled product SHALL be the signed full product arithmetically shifted right by COEF_W-1 (rounding per REQ-027/028).
REQ-018 With acc_in=0: result_out = scaled product; with acc_in=1: result_out = saturate(scaled product + previous result_out), summed at SIG_W+1 bits.
REQ-019 Saturation SHALL clamp to +2^(SIG_W-1)-1 / -2^(SIG_W-1) and set ovf=1; otherwise ovf=0.
REQ-020 start asserted while not in IDLE SHALL be ignored (no queueing); operand changes during MUL/FIN SHALL not affect the result.
REQ-021 Non-accumulate products SHALL never saturate (|coef|<1); ovf SHALL be 0 for acc_in=0.

Reset
REQ-022 rst=1 SHALL asynchronously force: state IDLE, result_out=0, ovf=0, done=1, accumulator and operand registers=0.
REQ-023 rst asserted mid-operation SHALL abort the operation with no result_out update; after deassertion the first sampled start SHALL behave per REQ-014.
REQ-024 start while rst=1 SHALL be ignored.
REQ-025 An accumulate after reset SHALL use previous result_out = 0.

Configuration
REQ-026 Macro SPMAC_ROUND_EN SHALL select the scaling rounding mode.
REQ-027 With SPMAC_ROUND_EN defined: add 2^(COEF_W-2) to the signed full product before the shift (round half up); latency unchanged.
REQ-028 Without SPMAC_ROUND_EN: plain arithmetic shift (truncation toward minus infinity).

Verification
REQ-029 Basic: sig_in=16384, coef_in=10'h100, acc_in=0, start at E0 -> done low E1..E9, result_out=8192, ovf=0, done=1 at E10.
REQ-030 Negative coef: sig_in=1000, coef_in=10'h300 -> result_out=-500; coef_in=10'h200 (-0) -> result_out=0.
REQ-031 Accumulate/saturate: prior result 30000, sig_in=16384, coef_in=10'h100, acc_in=1 -> result_out=32767, ovf=1; next op acc_in=0, sig_in=1000, coef_in=10'h100 -> result_out=500, ovf=0.
REQ-032 Rounding: sig_in=3, coef_in=10'h100 -> 1 (macro off) / 2 (macro on); coef_in=10'h300 -> -2 (off) / -1 (on).
REQ-033 Reset mid-op: start at E0, rst pulsed during E5 -> done=1, result_out=0, ovf=0 immediately; new start at defaults completes 10 edges later with correct value.
REQ-034 Busy start: second start pulsed at E3 with different operands -> ignored; only the first result appears at E10.
